// File: rtl/data_mem_responder.sv
// Word-addressed load/store responder: holds the pipeline for WAIT_CYCLES wait states, then
// completes against an internal array with a one-cycle Done (and Error for illegal requests).
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              Done,
    output logic              Error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);
    localparam int         DEPTH   = 1 << ADDR_W;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_op_wr;
    logic              r_err;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_req;
    logic              w_legal;
    logic              w_idle;
    logic              w_fast;
    logic              w_commit;
    logic              w_acc_wr;
    logic [ADDR_W-1:0] w_addr_idx;
    logic [ADDR_W-1:0] w_acc_idx;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_unused;

    assign w_req      = MemRead | MemWrite;
    assign w_legal    = (MemRead ^ MemWrite) && (Addr[1:0] == 2'b00);
    assign w_idle     = (r_state == S_IDLE);
    assign w_addr_idx = Addr[ADDR_W+1:2];
    assign w_unused   = ^{Addr[31:ADDR_W+2]};

    // With zero wait states the access is taken straight from the inputs on the accepting edge.
    assign w_fast      = w_idle && w_legal && (LP_WAIT == 4'd0);
    assign w_commit    = w_fast || ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_acc_wr    = w_fast ? MemWrite   : r_op_wr;
    assign w_acc_idx   = w_fast ? w_addr_idx : r_idx;
    assign w_acc_wdata = w_fast ? WriteData  : r_wdata;

    assign Stall    = (w_idle && w_req) || (r_state == S_WAIT);
    assign Done     = (r_state == S_RESP);
    assign Error    = (r_state == S_RESP) && r_err;
    assign ReadData = r_rdata;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op_wr <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_commit && !w_acc_wr) begin
                r_rdata <= r_mem[w_acc_idx];
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_err <= !w_legal;
                        if (w_legal) begin
                            r_op_wr <= MemWrite;
                            r_idx   <= w_addr_idx;
                            r_wdata <= WriteData;
                        end
                        if (!w_legal || LP_WAIT == 4'd0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= LP_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Contents deliberately survive Reset.
    always_ff @(posedge Clock) begin
        if (w_commit && w_acc_wr) begin
            r_mem[w_acc_idx] <= w_acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance 0 runs with two wait states, instance 1 with none.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        rd_i    [2];
    logic        wr_i    [2];
    logic [31:0] addr_i  [2];
    logic [31:0] wd_i    [2];
    logic [31:0] rdata_o [2];
    logic        stall_o [2];
    logic        done_o  [2];
    logic        err_o   [2];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2)) dut_w2 (
        .Clock(clk), .Reset(rst_n), .MemRead(rd_i[0]), .MemWrite(wr_i[0]),
        .Addr(addr_i[0]), .WriteData(wd_i[0]), .ReadData(rdata_o[0]),
        .Stall(stall_o[0]), .Done(done_o[0]), .Error(err_o[0])
    );

    data_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (
        .Clock(clk), .Reset(rst_n), .MemRead(rd_i[1]), .MemWrite(wr_i[1]),
        .Addr(addr_i[1]), .WriteData(wd_i[1]), .ReadData(rdata_o[1]),
        .Stall(stall_o[1]), .Done(done_o[1]), .Error(err_o[1])
    );

    // Drives one request on instance s and holds it until Done; reports what was observed.
    task automatic xact(input int s, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data,
                        output int n_stall, output int n_cyc, output logic done,
                        output logic err, output logic stall_resp,
                        output logic [31:0] rdat, output logic [31:0] rdat_first);
        n_stall = 0; n_cyc = -1; done = 1'b0; err = 1'b0; stall_resp = 1'b1;
        rdat = '0; rdat_first = '0;
        @(negedge clk);
        rd_i[s] = rd; wr_i[s] = wr; addr_i[s] = addr; wd_i[s] = data;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (i == 0) rdat_first = rdata_o[s];
            if (done_o[s]) begin
                done = 1'b1; err = err_o[s]; stall_resp = stall_o[s];
                rdat = rdata_o[s]; n_cyc = i;
                break;
            end
            if (stall_o[s]) n_stall++;
            @(negedge clk);
        end
        rd_i[s] = 1'b0; wr_i[s] = 1'b0;
    endtask

    int          ns, nc;
    logic        dn, er, sr;
    logic [31:0] rdv, rd0;

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            rd_i[s] = 1'b0; wr_i[s] = 1'b0; addr_i[s] = '0; wd_i[s] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if ({done_o[s], err_o[s], stall_o[s]} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_flags[%0d]: got done/err/stall=%b%b%b want 000", s, done_o[s], err_o[s], stall_o[s]);
            end
            n_cmp++;
            if (rdata_o[s] !== 32'h0) begin
                n_bad++; $display("FAIL reset_rdata[%0d]: got %h want 0", s, rdata_o[s]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        xact(0, 1'b0, 1'b1, 32'h10, 32'h12345678, ns, nc, dn, er, sr, rdv, rd0);
        n_cmp++;
        if (ns !== 3 || nc !== 3 || dn !== 1'b1) begin
            n_bad++; $display("FAIL w2_store_timing: stall=%0d done_cyc=%0d done=%b want 3/3/1", ns, nc, dn);
        end
        n_cmp++;
        if (er !== 1'b0 || sr !== 1'b0 || rdv !== 32'h0) begin
            n_bad++; $display("FAIL w2_store_resp: err=%b stall=%b rdata=%h want 0/0/00000000", er, sr, rdv);
        end
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0, ns, nc, dn, er, sr, rdv, rd0);
        n_cmp++;
        if (ns !== 3 || nc !== 3 || dn !== 1'b1 || er !== 1'b0) begin
            n_bad++; $display("FAIL w2_load_timing: stall=%0d done_cyc=%0d done=%b err=%b want 3/3/1/0", ns, nc, dn, er);
        end
        n_cmp++;
        if (rdv !== 32'h12345678) begin
            n_bad++; $display("FAIL w2_load_data: got %h want 12345678", rdv);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (done_o[0] !== 1'b0 || stall_o[0] !== 1'b0 || rdata_o[0] !== 32'h12345678) begin
            n_bad++; $display("FAIL w2_after_resp: done=%b stall=%b rdata=%h want 0/0/12345678", done_o[0], stall_o[0], rdata_o[0]);
        end
    endtask

    task automatic test_zero_wait();
        xact(1, 1'b0, 1'b1, 32'h10, 32'h12345678, ns, nc, dn, er, sr, rdv, rd0);
        n_cmp++;
        if (ns !== 1 || nc !== 1 || dn !== 1'b1 || er !== 1'b0) begin
            n_bad++; $display("FAIL w0_store_timing: stall=%0d done_cyc=%0d done=%b err=%b want 1/1/1/0", ns, nc, dn, er);
        end
        xact(1, 1'b0, 1'b1, 32'h14, 32'h9ABCDEF0, ns, nc, dn, er, sr, rdv, rd0);
        xact(1, 1'b1, 1'b0, 32'h10, 32'h0, ns, nc, dn, er, sr, rdv, rd0);
        n_cmp++;
        if (ns !== 1 || nc !== 1 || dn !== 1'b1 || rdv !== 32'h12345678) begin
            n_bad++; $display("FAIL w0_load: stall=%0d done_cyc=%0d done=%b rdata=%h want 1/1/1/12345678", ns, nc, dn, rdv);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rd_i[1] = 1'b1; addr_i[1] = 32'h10; #1;
        n_cmp++;
        if (stall_o[1] !== 1'b1 || done_o[1] !== 1'b0) begin
            n_bad++; $display("FAIL b2b_c0: stall=%b done=%b want 1/0", stall_o[1], done_o[1]);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (done_o[1] !== 1'b1 || rdata_o[1] !== 32'h12345678) begin
            n_bad++; $display("FAIL b2b_c1: done=%b rdata=%h want 1/12345678", done_o[1], rdata_o[1]);
        end
        addr_i[1] = 32'h14; #1;
        n_cmp++;
        if (stall_o[1] !== 1'b0) begin
            n_bad++; $display("FAIL b2b_resp_stall: got %b want 0", stall_o[1]);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (stall_o[1] !== 1'b1 || done_o[1] !== 1'b0) begin
            n_bad++; $display("FAIL b2b_c2: stall=%b done=%b want 1/0", stall_o[1], done_o[1]);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (done_o[1] !== 1'b1 || rdata_o[1] !== 32'h9ABCDEF0) begin
            n_bad++; $display("FAIL b2b_c3: done=%b rdata=%h want 1/9abcdef0", done_o[1], rdata_o[1]);
        end
        rd_i[1] = 1'b0;
    endtask

    task automatic test_wrap();
        xact(0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, ns, nc, dn, er, sr, rdv, rd0);
        xact(0, 1'b1, 1'b0, 32'h000, 32'h0, ns, nc, dn, er, sr, rdv, rd0);
        n_cmp++;
        if (dn !== 1'b1 || rdv !== 32'hA5A5A5A5) begin
            n_bad++; $display("FAIL wrap_load: done=%b rdata=%h want 1/a5a5a5a5", dn, rdv);
        end
    endtask

    task automatic test_misaligned();
        xact(0, 1'b1, 1'b0, 32'h13, 32'h0, ns, nc, dn, er, sr, rdv, rd0);
        n_cmp++;
        if (ns !== 1 || nc !== 1 || dn !== 1'b1 || er !== 1'b1) begin
            n_bad++; $display("FAIL misalign_flags: stall=%0d done_cyc=%0d done=%b err=%b want 1/1/1/1", ns, nc, dn, er);
        end
        n_cmp++;
        if (rdv !== 32'hA5A5A5A5) begin
            n_bad++; $display("FAIL misalign_rdata: got %h want a5a5a5a5", rdv);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (err_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
            n_bad++; $display("FAIL misalign_pulse: err=%b done=%b want 0/0", err_o[0], done_o[0]);
        end
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0, ns, nc, dn, er, sr, rdv, rd0);
        n_cmp++;
        if (er !== 1'b0 || rdv !== 32'h12345678) begin
            n_bad++; $display("FAIL misalign_followup: err=%b rdata=%h want 0/12345678", er, rdv);
        end
    endtask

    task automatic test_both_ops();
        xact(0, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, ns, nc, dn, er, sr, rdv, rd0);
        xact(0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, ns, nc, dn, er, sr, rdv, rd0);
        n_cmp++;
        if (ns !== 1 || nc !== 1 || dn !== 1'b1 || er !== 1'b1) begin
            n_bad++; $display("FAIL both_flags: stall=%0d done_cyc=%0d done=%b err=%b want 1/1/1/1", ns, nc, dn, er);
        end
        n_cmp++;
        if (rdv !== 32'h12345678) begin
            n_bad++; $display("FAIL both_rdata: got %h want 12345678", rdv);
        end
        xact(0, 1'b1, 1'b0, 32'h20, 32'h0, ns, nc, dn, er, sr, rdv, rd0);
        n_cmp++;
        if (rdv !== 32'h0BADF00D) begin
            n_bad++; $display("FAIL both_nowrite: got %h want 0badf00d", rdv);
        end
    endtask

    task automatic test_reset_mid_wait();
        xact(0, 1'b0, 1'b1, 32'h30, 32'h22222222, ns, nc, dn, er, sr, rdv, rd0);
        @(negedge clk);
        wr_i[0] = 1'b1; addr_i[0] = 32'h30; wd_i[0] = 32'h11111111; #1;
        n_cmp++;
        if (stall_o[0] !== 1'b1) begin
            n_bad++; $display("FAIL rst_req_stall: got %b want 1", stall_o[0]);
        end
        @(negedge clk);
        rst_n = 1'b0; wr_i[0] = 1'b0; #1;
        n_cmp++;
        if ({done_o[0], err_o[0], stall_o[0]} !== 3'b000 || rdata_o[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_mid_wait: done/err/stall=%b%b%b rdata=%h want 000/00000000", done_o[0], err_o[0], stall_o[0], rdata_o[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (done_o[0] !== 1'b0 || rdata_o[0] !== 32'h0) begin
            n_bad++; $display("FAIL rst_after_release: done=%b rdata=%h want 0/00000000", done_o[0], rdata_o[0]);
        end
        xact(0, 1'b1, 1'b0, 32'h30, 32'h0, ns, nc, dn, er, sr, rdv, rd0);
        n_cmp++;
        if (rd0 !== 32'h0) begin
            n_bad++; $display("FAIL rst_rdata_before_load: got %h want 0", rd0);
        end
        n_cmp++;
        if (dn !== 1'b1 || rdv !== 32'h22222222) begin
            n_bad++; $display("FAIL rst_store_discarded: done=%b rdata=%h want 1/22222222", dn, rdv);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_zero_wait();
        test_back_to_back();
        test_wrap();
        test_misaligned();
        test_both_ops();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
